// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the two-client memory arbiter.
// Grant state encoding and client IDs used by mem_arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } arb_state_t;

  localparam int CLIENT_I = 0;
  localparam int CLIENT_D = 1;

endpackage

// File: rtl/mem_arb_credit.sv
// mem_arb_credit: outstanding-read up/down counter.
// Ports: i_clk, i_rst (sync, high), i_inc (read accepted),
// i_dec (read data returned), o_full (count == MAX), o_empty.
module mem_arb_credit #(
  parameter int MAX = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full,
  output logic o_empty
);

  localparam int W = $clog2(MAX) + 1;

  logic [W-1:0] cnt_q, cnt_d;
  logic         dec;

  assign o_empty = (cnt_q == '0);
  assign o_full  = (cnt_q == W'(MAX));

  // A return with nothing outstanding is a stray; drop it.
  assign dec = i_dec & ~o_empty;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({i_inc, dec})
      2'b10:   cnt_d = cnt_q + W'(1);
      2'b01:   cnt_d = cnt_q - W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants icache (c0) or dcache (c1) the single memory port,
// holding the grant until the owner is idle and its reads have drained.
// Ports: i_clk, i_rst (sync, high); per client i_cX_addr/ren/wen/wdata,
// o_cX_ready/rdata/valid; memory o_mem_addr/ren/wen/wdata, i_mem_ready,
// i_mem_rdata, i_mem_valid.
// Option: MEM_ARB_BURST_LIMIT_EN forces release after MAX_GRANT
// accepted transactions when the other client is waiting.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int MAX_GRANT       = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_c0_addr,
  input  logic        i_c0_ren,
  input  logic        i_c0_wen,
  input  logic [31:0] i_c0_wdata,
  output logic        o_c0_ready,
  output logic [31:0] o_c0_rdata,
  output logic        o_c0_valid,
  input  logic [31:0] i_c1_addr,
  input  logic        i_c1_ren,
  input  logic        i_c1_wen,
  input  logic [31:0] i_c1_wdata,
  output logic        o_c1_ready,
  output logic [31:0] o_c1_rdata,
  output logic        o_c1_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_valid
);

  arb_state_t  state_q, state_d;
  logic        last_q, last_d;
  logic        c0_req, c1_req;
  logic        own_ren, own_wen, own_req;
  logic [31:0] own_addr, own_wdata;
  logic        eff_ren, block, rdy;
  logic        burst_hit, rel;
  logic        full, empty;

  assign c0_req = i_c0_ren | i_c0_wen;
  assign c1_req = i_c1_ren | i_c1_wen;

  always_comb begin
    own_ren   = 1'b0;
    own_wen   = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    unique case (state_q)
      OWN0: begin
        own_ren   = i_c0_ren;
        own_wen   = i_c0_wen;
        own_addr  = i_c0_addr;
        own_wdata = i_c0_wdata;
      end
      OWN1: begin
        own_ren   = i_c1_ren;
        own_wen   = i_c1_wen;
        own_addr  = i_c1_addr;
        own_wdata = i_c1_wdata;
      end
      default: ;
    endcase
  end

  assign own_req = own_ren | own_wen;
  // Write wins over an illegal simultaneous read.
  assign eff_ren = own_ren & ~own_wen;
  assign block   = (full & own_ren) | burst_hit;
  assign rdy     = i_mem_ready & ~block & (state_q != IDLE);

`ifdef MEM_ARB_BURST_LIMIT_EN
  localparam int GW = $clog2(MAX_GRANT) + 1;

  logic [GW-1:0] bcnt_q, bcnt_d;
  logic          oth_req;

  assign oth_req   = (state_q == OWN0) ? c1_req :
                     (state_q == OWN1) ? c0_req : 1'b0;
  assign burst_hit = (bcnt_q == GW'(MAX_GRANT)) & oth_req;

  // Saturates so a late-arriving competitor is blocked at once.
  always_comb begin
    bcnt_d = bcnt_q;
    if (state_d != state_q) begin
      bcnt_d = '0;
    end else if (rdy & own_req & (bcnt_q != GW'(MAX_GRANT))) begin
      bcnt_d = bcnt_q + GW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
    end
  end

  assign o_mem_wen = own_wen & ~burst_hit;
`else
  assign burst_hit = 1'b0 & (MAX_GRANT == 0);
  assign o_mem_wen = own_wen;
`endif

  assign o_mem_ren   = eff_ren & ~block;
  assign o_mem_addr  = own_addr;
  assign o_mem_wdata = own_wdata;

  assign o_c0_ready = rdy & (state_q == OWN0);
  assign o_c1_ready = rdy & (state_q == OWN1);

  assign o_c0_rdata = i_mem_rdata;
  assign o_c1_rdata = i_mem_rdata;
  assign o_c0_valid = i_mem_valid & (state_q == OWN0) & ~empty;
  assign o_c1_valid = i_mem_valid & (state_q == OWN1) & ~empty;

  mem_arb_credit #(
    .MAX(MAX_OUTSTANDING)
  ) u_credit (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_inc  (eff_ren & rdy),
    .i_dec  (i_mem_valid),
    .o_full (full),
    .o_empty(empty)
  );

  assign rel = (~own_req | burst_hit) & empty;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (c0_req & c1_req) begin
          state_d = last_q ? OWN0 : OWN1;
        end else if (c0_req) begin
          state_d = OWN0;
        end else if (c1_req) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (rel) begin
          last_d  = 1'(CLIENT_I);
          state_d = c1_req ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (rel) begin
          last_d  = 1'(CLIENT_D);
          state_d = c0_req ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      last_q  <= 1'(CLIENT_D);
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a latency-
// configurable memory model and per-client read-data scoreboards.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] c0_addr = '0, c1_addr = '0;
  logic        c0_ren = 1'b0, c0_wen = 1'b0;
  logic        c1_ren = 1'b0, c1_wen = 1'b0;
  logic [31:0] c0_wdata = '0, c1_wdata = '0;
  logic        c0_ready, c1_ready, c0_valid, c1_valid;
  logic [31:0] c0_rdata, c1_rdata;
  logic        mem_rdy = 1'b1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ren, mem_wen, mem_valid;

  int checks = 0;
  int errors = 0;
  int lat = 2;
  int acc0 = 0, acc1 = 0, nv0 = 0, nv1 = 0, stray = 0;

  req_t        rq0[$], rq1[$];
  logic [31:0] exp0[$], exp1[$];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_c0_addr(c0_addr), .i_c0_ren(c0_ren), .i_c0_wen(c0_wen),
    .i_c0_wdata(c0_wdata), .o_c0_ready(c0_ready),
    .o_c0_rdata(c0_rdata), .o_c0_valid(c0_valid),
    .i_c1_addr(c1_addr), .i_c1_ren(c1_ren), .i_c1_wen(c1_wen),
    .i_c1_wdata(c1_wdata), .o_c1_ready(c1_ready),
    .o_c1_rdata(c1_rdata), .o_c1_valid(c1_valid),
    .i_mem_ready(mem_rdy), .o_mem_addr(mem_addr),
    .o_mem_ren(mem_ren), .o_mem_wen(mem_wen),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
    .i_mem_valid(mem_valid)
  );

  function automatic logic [31:0] mf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory model: in-order, fixed latency.
  logic [15:0] vp = '0;
  logic [31:0] dp[16];
  logic        m_acc = 1'b0;
  logic [31:0] m_a = '0;

  assign mem_valid = vp[0];
  assign mem_rdata = vp[0] ? dp[0] : 32'h0BAD_F00D;

  always @(negedge clk) begin
    m_acc = mem_ren & mem_rdy;
    m_a   = mem_addr;
  end

  always @(posedge clk) begin
    logic [15:0] nv;
    nv = vp >> 1;
    for (int i = 0; i < 15; i++) dp[i] <= dp[i+1];
    if (m_acc) begin
      nv[lat-1] = 1'b1;
      dp[lat-1] <= mf(m_a);
    end
    vp <= nv;
  end

  // Client drivers: hold request until accepted, push expected data.
  logic a0_s = 1'b0, a1_s = 1'b0;
  always @(negedge clk) a0_s = c0_ready & (c0_ren | c0_wen);
  always @(negedge clk) a1_s = c1_ready & (c1_ren | c1_wen);

  always @(posedge clk) begin
    #1;
    if (rst) begin
      rq0.delete(); exp0.delete();
      c0_ren = 1'b0; c0_wen = 1'b0;
    end else begin
      if (a0_s && rq0.size() != 0) begin
        if (!rq0[0].wr) exp0.push_back(mf(rq0[0].a));
        void'(rq0.pop_front());
        acc0++;
      end
      if (rq0.size() != 0) begin
        c0_ren = !rq0[0].wr; c0_wen = rq0[0].wr;
        c0_addr = rq0[0].a; c0_wdata = rq0[0].d;
      end else begin
        c0_ren = 1'b0; c0_wen = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst) begin
      rq1.delete(); exp1.delete();
      c1_ren = 1'b0; c1_wen = 1'b0;
    end else begin
      if (a1_s && rq1.size() != 0) begin
        if (!rq1[0].wr) exp1.push_back(mf(rq1[0].a));
        void'(rq1.pop_front());
        acc1++;
      end
      if (rq1.size() != 0) begin
        c1_ren = !rq1[0].wr; c1_wen = rq1[0].wr;
        c1_addr = rq1[0].a; c1_wdata = rq1[0].d;
      end else begin
        c1_ren = 1'b0; c1_wen = 1'b0;
      end
    end
  end

  // Response monitor / scoreboard pop.
  always @(negedge clk) begin
    if (c0_valid) begin
      nv0++;
      chk("c0_valid_expected", 32'(exp0.size() != 0), 1);
      if (exp0.size() != 0) chk("c0_rdata", c0_rdata, exp0.pop_front());
    end
    if (c1_valid) begin
      nv1++;
      chk("c1_valid_expected", 32'(exp1.size() != 0), 1);
      if (exp1.size() != 0) chk("c1_rdata", c1_rdata, exp1.pop_front());
    end
    if (mem_valid && !c0_valid && !c1_valid) stray++;
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(dut.state_q == IDLE && rq0.size() == 0 &&
                 rq1.size() == 0 && exp0.size() == 0 &&
                 exp1.size() == 0) && n < 300);
    chk(tag, 32'(n < 300), 1);
  endtask

  task automatic wait_c0_req(input string tag);
    int n = 0;
    while (c0_ren !== 1'b1 && c0_wen !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 50), 1);
  endtask

  initial begin
    int b0, b1, bv0, bs, n;
    arb_state_t prev;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_last", 32'(dut.last_q), 1);
    chk("rst_count", 32'(dut.u_credit.cnt_q), 0);
    chk("rst_mem_ren", 32'(mem_ren), 0);
    chk("rst_mem_wen", 32'(mem_wen), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_ready", 32'({c0_ready, c1_ready}), 0);
    chk("rst_valid", 32'({c0_valid, c1_valid}), 0);
    chk("rst_rdata", c0_rdata, mem_rdata);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);

    // Tie after reset: c0 first, then direct handoff to c1
    b0 = acc0; b1 = acc1;
    for (int i = 0; i < 4; i++) begin
      rq0.push_back('{1'b0, 32'h300 + 32'(4*i), '0});
      rq1.push_back('{1'b0, 32'h400 + 32'(4*i), '0});
    end
    wait_c0_req("tie_req_seen");
    @(negedge clk);
    chk("tie_c0_ready", 32'(c0_ready), 1);
    chk("tie_c1_ready", 32'(c1_ready), 0);
    prev = dut.state_q; n = 0;
    while (dut.state_q != OWN1 && n < 100) begin
      prev = dut.state_q;
      @(negedge clk);
      n++;
    end
    chk("tie_handoff_prev", 32'(prev), 32'(OWN0));
    wait_idle("tie_drain");
    chk("tie_acc", 32'((acc0 - b0) + (acc1 - b1)), 8);

    // Single fill by c0, latency 2
    b0 = acc0; bv0 = nv0;
    for (int i = 0; i < 4; i++)
      rq0.push_back('{1'b0, 32'h100 + 32'(4*i), '0});
    wait_c0_req("fill_req_seen");
    chk("fill_idle_ready", 32'(c0_ready), 0);
    chk("fill_idle_ren", 32'(mem_ren), 0);
    @(negedge clk);
    chk("fill_grant_ready", 32'(c0_ready), 1);
    chk("fill_first_addr", mem_addr, 32'h100);
    chk("fill_first_ren", 32'(mem_ren), 1);
    wait_idle("fill_drain");
    chk("fill_acc", 32'(acc0 - b0), 4);
    chk("fill_valids", 32'(nv0 - bv0), 4);
    chk("fill_state", 32'(dut.state_q), 32'(IDLE));

    // Next tie goes to c1
    rq0.push_back('{1'b0, 32'h700, '0});
    rq1.push_back('{1'b0, 32'h800, '0});
    wait_c0_req("tie2_req_seen");
    @(negedge clk);
    chk("tie2_c1_ready", 32'(c1_ready), 1);
    chk("tie2_c0_ready", 32'(c0_ready), 0);
    wait_idle("tie2_drain");

    // Outstanding cap, latency 10, six reads by c1
    lat = 10;
    b1 = acc1;
    for (int i = 0; i < 6; i++)
      rq1.push_back('{1'b0, 32'h900 + 32'(4*i), '0});
    repeat (8) @(negedge clk);
    chk("cap_acc4", 32'(acc1 - b1), 4);
    chk("cap_blocked", 32'(c1_ready), 0);
    chk("cap_req_held", 32'(c1_ren), 1);
    n = 0;
    while (!c1_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("cap_valid_seen", 32'(n < 30), 1);
    chk("cap_ready_at_valid", 32'(c1_ready), 0);
    chk("cap_acc_at_valid", 32'(acc1 - b1), 4);
    @(negedge clk);
    chk("cap_fifth_ready", 32'(c1_ready), 1);
    wait_idle("cap_drain");
    chk("cap_acc6", 32'(acc1 - b1), 6);
    lat = 2;

    // Write pass-through with memory stalling 3 cycles
    mem_rdy = 1'b0;
    rq1.push_back('{1'b1, 32'h200, 32'hDEAD_BEEF});
    n = 0;
    while (c1_wen !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wr_req_seen", 32'(n < 50), 1);
    chk("wr_idle_wen", 32'(mem_wen), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wr_hold_wen", 32'(mem_wen), 1);
      chk("wr_hold_addr", mem_addr, 32'h200);
      chk("wr_hold_data", mem_wdata, 32'hDEAD_BEEF);
      chk("wr_hold_ready", 32'(c1_ready), 0);
    end
    @(posedge clk); #2 mem_rdy = 1'b1;
    @(negedge clk);
    chk("wr_ready_4th", 32'(c1_ready), 1);
    chk("wr_no_ren", 32'(mem_ren), 0);
    wait_idle("wr_drain");
    chk("wr_count", 32'(dut.u_credit.cnt_q), 0);

    // Reset with two reads outstanding, then stray valids
    lat = 4;
    b0 = acc0;
    rq0.push_back('{1'b0, 32'hA00, '0});
    rq0.push_back('{1'b0, 32'hA04, '0});
    n = 0;
    while (acc0 - b0 < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rstm_acc2", 32'(acc0 - b0), 2);
    @(posedge clk); #2;
    rst = 1'b1; mem_rdy = 1'b0; bs = stray; bv0 = nv0;
    @(posedge clk); #2;
    rst = 1'b0; mem_rdy = 1'b1;
    repeat (6) @(negedge clk);
    chk("rstm_strays", 32'(stray - bs), 2);
    chk("rstm_no_valid", 32'(nv0 - bv0), 0);
    chk("rstm_state", 32'(dut.state_q), 32'(IDLE));
    chk("rstm_count", 32'(dut.u_credit.cnt_q), 0);
    lat = 2;

`ifdef MEM_ARB_BURST_LIMIT_EN
    // Burst limit: c0 streams, c1 waits
    b0 = acc0; b1 = acc1;
    for (int i = 0; i < 12; i++)
      rq0.push_back('{1'b0, 32'h500 + 32'(4*i), '0});
    rq1.push_back('{1'b0, 32'h600, '0});
    n = 0;
    while (acc0 - b0 < 8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("burst_acc8", 32'(acc0 - b0), 8);
    chk("burst_ready_drop", 32'(c0_ready), 0);
    chk("burst_c0_req", 32'(c0_ren), 1);
    n = 0;
    while (dut.state_q != OWN1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("burst_c1_grant", 32'(dut.state_q), 32'(OWN1));
    chk("burst_acc_at_grant", 32'(acc0 - b0), 8);
    wait_idle("burst_drain");
    chk("burst_acc0_total", 32'(acc0 - b0), 12);
    chk("burst_acc1_total", 32'(acc1 - b1), 1);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-client arbiter between the instruction cache and data cache memory ports and the single external word-granular memory interface. Each cache presents the same ready/addr/ren/wen/wdata/rdata/valid interface it would drive to memory. The arbiter grants one client at a time and tracks outstanding reads so `i_mem_valid` returns to the correct cache. A grant is held across a cache-line fill and released only when the owner is idle and fully drained.

## Interface
Parameters:
- `MAX_OUTSTANDING`, 4: maximum accepted-but-unreturned reads.
- `MAX_GRANT`, 8: accepted transactions per grant before forced release. Used only with `MEM_ARB_BURST_LIMIT_EN`.

Ports. The clock is `i_clk`. Reset `i_rst` is synchronous and active-high. One clock domain.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  synchronous active-high reset.
- `i_c0_addr`  in  32  client 0 (icache) word address.
- `i_c0_ren`, `i_c0_wen`  in  1  client 0 read/write request.
- `i_c0_wdata`  in  32  client 0 write data.
- `o_c0_ready`  out  1  client 0 request accepted this cycle.
- `o_c0_rdata`  out  32  read data.
- `o_c0_valid`  out  1  client 0 read data valid.
- `i_c1_*`, `o_c1_*`  same set for client 1 (dcache).
- `i_mem_ready`  in  1  memory accepts the request.
- `o_mem_addr`  out  32  memory address.
- `o_mem_ren`, `o_mem_wen`  out  1  memory request.
- `o_mem_wdata`  out  32  memory write data.
- `i_mem_rdata`  in  32  memory read data.
- `i_mem_valid`  in  1  memory read data valid.

## Operation
- **States:** IDLE, OWN0, OWN1. Register `last` holds the most recent owner. Reset sets `last` = 1, so client 0 wins the first tie.
- **IDLE:**
  - Nothing is forwarded: `o_mem_*` = 0 and both readies are 0.
  - If exactly one client requests (ren|wen), the next state is that client's OWN state.
  - If both request, the next state is OWN(!`last`).
- **OWNx:**
  - Owner's addr, wdata and request lines pass combinationally to `o_mem_*`.
  - `o_cx_ready` = `i_mem_ready` & ~block; the other client's ready is 0.
  - `o_mem_ren` is additionally gated by block.
  - block = (count == `MAX_OUTSTANDING` & owner ren), plus the burst-limit condition when that feature is compiled in.
  - If the owner asserts both ren and wen (illegal), wen is forwarded and ren is suppressed.
- **Outstanding count:** width `$clog2(MAX_OUTSTANDING)+1`.
  - +1 on an accepted read (owner ren & `o_cx_ready`).
  - −1 on `i_mem_valid`.
  - Both in the same cycle: unchanged.
  - `i_mem_valid` with count 0 is dropped; the count does not underflow.
- **Responses:**
  - `o_c0_rdata` = `o_c1_rdata` = `i_mem_rdata`.
  - `o_cx_valid` = `i_mem_valid` & (state == OWNx) & count != 0.
- **Release:** allowed when the owner has no request this cycle and the registered count == 0.
  - Go to the other OWN state if the other client requests (no bubble); otherwise go to IDLE.
  - `last` updates on release.
- **Client rule:** hold ren/wen, addr and wdata stable until ready is seen high.

## Timing
- A request arriving in IDLE is accepted no earlier than the next cycle (one-cycle grant latency).
- Within a grant, acceptance is zero-latency when `i_mem_ready` is high.
- Read data has memory latency plus 0 cycles; valid is routed combinationally.
- Writes are complete on acceptance and do not count as outstanding.
- Reset values:
  - state IDLE, count 0, `last` 1, burst counter 0.
  - All `o_mem_*`, readies and valids are 0.
  - rdata follows `i_mem_rdata`.
- Reset mid-burst discards outstanding state; late `i_mem_valid` pulses are then dropped.

## Configuration
- **`MEM_ARB_BURST_LIMIT_EN` defined:**
  - A per-grant counter counts accepted transactions.
  - Once it reaches `MAX_GRANT` and the other client is requesting, the owner's ready is forced to 0.
  - Release occurs when count reaches 0, regardless of the owner's request.
  - The counter clears on every grant change.
- **Undefined:** no counter; the grant is held until the owner goes idle and drains.

## Structure
- Package `mem_arb_pkg` contains:
  - state enum `arb_state_t` (IDLE, OWN0, OWN1);
  - client ID localparams `CLIENT_I` = 0 and `CLIENT_D` = 1.
- One sub-module, `mem_arb_credit`: the outstanding up/down counter with full/empty flags.

## Test plan
- **Single fill:** c0 reads 0x100, 0x104, 0x108, 0x10C with `i_mem_ready` = 1 and memory latency 2.
  - Grant in cycle 1; four acceptances; four `o_c0_valid` pulses carrying the memory data.
  - `o_c1_valid` stays 0; return to IDLE when drained.
- **Tie:** both request in IDLE after reset.
  - c0 is granted first.
  - After c0 drains, c1 is granted directly with no IDLE cycle.
  - The next tie goes to c1.
- **Outstanding cap:** memory latency 10, c1 issues 6 reads.
  - Exactly 4 are accepted; `o_c1_ready` is 0 until the first valid returns, then the fifth is accepted.
- **Write pass-through:** c1 writes 0xDEADBEEF to 0x200 while `i_mem_ready` is low for 3 cycles.
  - `o_mem_wen`, addr and wdata are held.
  - Ready is seen in the 4th cycle; count stays 0.
- **Reset mid-fill, then stray valid:** reset with 2 reads outstanding, then 2 `i_mem_valid` pulses.
  - No client valid; state IDLE; count 0.
- **Burst limit (with `MEM_ARB_BURST_LIMIT_EN`, `MAX_GRANT` = 8):** c0 streams while c1 waits.
  - After 8 acceptances, c0's ready drops.
  - c1 is granted once c0's reads drain.
